// File: rtl/d_mem_sized_if.sv
// rtl/d_mem_sized_if.sv - load/store bus between the MEM stage and the data memory
interface d_mem_sized_if #(
    parameter int ADDR_W = 32
) ();
    logic              we;
    logic              re;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wd;
    logic [31:0]       rd;
    logic              rd_valid;
    logic              busy;
    logic              err;

    modport master (
        output we, re, size, sign_ext, addr, wd,
        input  rd, rd_valid, busy, err
    );

    modport slave (
        input  we, re, size, sign_ext, addr, wd,
        output rd, rd_valid, busy, err
    );
endinterface

// File: rtl/d_mem_sized.sv
// rtl/d_mem_sized.sv - sized byte/half/word data memory with post-reset fill and fault detection
module d_mem_sized #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          ADDR_W      = 32,
    parameter logic [31:0] INIT_WORD   = 32'h0000_00FF,
    parameter bit          READ_REG    = 1'b0
) (
    input logic         clk,
    input logic         rst,
    d_mem_sized_if.slave bus
);
    localparam int              IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [0:0]      S_FILL   = 1'b0;
    localparam logic [0:0]      S_READY  = 1'b1;
    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(DEPTH_WORDS - 1);

    logic [31:0] ram [DEPTH_WORDS];

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;

    logic [ADDR_W-3:0] word_idx;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        lane;
    logic              misaligned;
    logic              out_of_range;
    logic              fault;
    logic              accepted_we;
    logic              accepted_re;
    logic              store_en;
    logic [31:0]       cur_word;
    logic [31:0]       shifted;
    logic [31:0]       load_data;
    logic [3:0]        be;
    logic [31:0]       wdata;

    assign word_idx     = bus.addr[ADDR_W-1:2];
    assign idx          = word_idx[IDX_W-1:0];
    assign lane         = bus.addr[1:0];
    assign out_of_range = 64'(word_idx) >= 64'(DEPTH_WORDS);
    assign fault        = misaligned | out_of_range;

    // Requests are only accepted in READY and never on a reset edge.
    assign accepted_we = bus.we & ~busy_q & ~rst;
    assign accepted_re = bus.re & ~busy_q & ~rst;
    assign store_en    = accepted_we & ~fault;

    always_comb begin
        misaligned = 1'b0;
        case (bus.size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = bus.addr[0];
            2'b10:   misaligned = (bus.addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Read-first: load data comes from the pre-edge array contents.
    assign cur_word = ram[idx];
    assign shifted  = cur_word >> {lane, 3'b000};

    always_comb begin
        load_data = '0;
        if (!fault) begin
            case (bus.size)
                2'b00:   load_data = {{24{bus.sign_ext & shifted[7]}}, shifted[7:0]};
                2'b01:   load_data = {{16{bus.sign_ext & shifted[15]}}, shifted[15:0]};
                default: load_data = cur_word;
            endcase
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be    = 4'b0000;
        wdata = bus.wd;
        case (bus.size)
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{bus.wd[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{bus.wd[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        err_d   = (accepted_we | accepted_re) & fault;
        if (state_q == S_FILL) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST_PTR) begin
                state_d = S_READY;
                busy_d  = 1'b0;
                ptr_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == S_FILL) begin
            ram[ptr_q] <= INIT_WORD;
        end else if (store_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    ram[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    generate
        if (READ_REG) begin : g_rd_reg
            logic [31:0] rd_q;
            logic        rd_valid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q       <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= accepted_re;
                    if (accepted_re) begin
                        rd_q <= load_data;
                    end
                end
            end

            assign bus.rd       = rd_q;
            assign bus.rd_valid = rd_valid_q;
        end else begin : g_rd_comb
            assign bus.rd_valid = bus.re & ~busy_q;
            assign bus.rd       = (bus.re & ~busy_q) ? load_data : '0;
        end
    endgenerate

    assign bus.busy = busy_q;
    assign bus.err  = err_q;
endmodule

// File: doc/d_mem_sized.md
Name: d_mem_sized

Overview:
- Parametrised data memory for the MIPS pipeline MEM stage, successor to the fixed 64-word word-only data RAM.
- Adds byte, halfword and word loads/stores with sign or zero extension, optional registered read port, and misaligned/out-of-range fault detection.
- Adds a post-reset hardware fill sequencer that writes INIT_WORD to every location, replacing simulation-only initialisation.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words; any value >= 2.
ADDR_W, 32, byte-address width.
INIT_WORD, 32'h0000_00FF, fill value written to every word after reset.
READ_REG, 0, 0 = combinational read data; 1 = read data registered, one-cycle latency.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
we  in  1  store request
re  in  1  load request
size  in  2  00 byte, 01 half, 10 word, 11 reserved
sign_ext  in  1  loads: 1 = sign-extend, 0 = zero-extend
addr  in  ADDR_W  byte address
wd  in  32  store data, right-justified (byte in [7:0], half in [15:0])
rd  out  32  load data, extended to 32 bits
rd_valid  out  1  rd is valid this cycle
busy  out  1  fill in progress; requests ignored
err  out  1  one-cycle fault pulse

Behaviour:
- Addressing:
  - word index = addr[ADDR_W-1:2]; lane = addr[1:0].
  - Little-endian lanes: byte at lane n occupies bits [8n+7:8n]; half at lane 0 or 2 occupies [15:0] or [31:16].
- Fault conditions:
  - misaligned: size=01 with addr[0]=1; size=10 with addr[1:0]!=0; size=11 always.
  - out of range: index >= DEPTH_WORDS.
  - A faulting store writes nothing.
  - A faulting load returns rd=0 and still asserts rd_valid on its normal cycle.
  - err is a registered pulse, high the cycle after any faulting request (we or re) accepted while not busy.
- Fill state machine, states FILL and READY:
  - rst=1 at an edge: state<=FILL, ptr<=0, busy<=1, err<=0, registered rd<=0, rd_valid<=0.
  - FILL, rst=0: ram[ptr]<=INIT_WORD and ptr<=ptr+1 each cycle. Writing ptr=DEPTH_WORDS-1 moves to READY and clears busy.
  - busy is therefore high for exactly DEPTH_WORDS cycles after the first edge with rst low.
  - rst asserted mid-fill restarts at ptr=0.
  - During FILL, we/re are ignored: no write, no err, rd_valid=0, rd=0.
- Store (READY, we=1, no fault):
  - Only the addressed byte lanes are written at the rising edge; the other lanes hold.
  - Byte store: wd[7:0] goes to lane n.
  - Half store: wd[15:0] goes to the addressed half.
  - Word store: all of wd is written.
- Load (READY, re=1):
  - Select the addressed lane(s); extend to 32 bits per sign_ext. Word loads ignore sign_ext.
  - READ_REG=0: rd and rd_valid are combinational from current inputs. rd_valid = re & ~busy. rd=0 when re=0.
  - READ_REG=1: rd is registered at the edge where re is sampled; rd_valid is high the following cycle only. rd holds its last value when rd_valid=0.
- Simultaneous we and re to the same word: read-first; the load returns pre-store contents and the store completes at the same edge.
- Back-to-back loads with READ_REG=1 give one result per cycle (fully pipelined).
- No X on rd after fill: any index read after busy falls returns defined data.

Test Plan:
- Reset/fill: rst high 2 cycles then low -> busy high exactly 64 cycles; then load word addr 0x0 and addr 0xFC -> rd=0x000000FF each. Reassert rst at fill cycle 10 -> busy restarts, again 64 cycles.
- Byte lanes: store word 0x11223344 @0x10, then byte 0xAA @0x12 -> word load @0x10 returns 0x11AA3344; byte load @0x12 sign_ext=1 -> 0xFFFFFFAA; sign_ext=0 -> 0x000000AA.
- Halves: store half 0x8001 @0x22 -> half load @0x22 sign_ext=1 -> 0xFFFF8001; sign_ext=0 -> 0x00008001; half @0x20 -> 0x00FF (from fill pattern).
- Faults: word store 0xDEADBEEF @0x05 -> err pulse next cycle; word load @0x04 still 0x000000FF. Load @0x100 (index 64) -> err, rd=0. size=11 -> err.
- READ_REG=1: loads @0x0,0x4,0x8 on consecutive cycles -> rd_valid high 3 consecutive cycles starting one cycle later, data in order. Same-cycle we+re @0x4 with wd=0x5 -> rd=old value, next load returns 0x5.
- Busy gating: store 0x12345678 @0x0 during fill -> no err; after fill, load @0x0 -> 0x000000FF.
